// File: rtl/sysbus_mem_responder.sv
// Purpose: memory-side system bus responder; serves 64-byte line fills and write-backs from a 64-bit word store.
// Latency: request ack one cycle after acceptance, first read beat READ_LATENCY cycles after the ack cycle.
// Backpressure: read/completion beats hold until bus_respack; write beats consumed only when bus_reqcyc is high.
module sysbus_mem_responder #(
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam logic [3:0] SYSBUS_READ  = 4'h1;
    localparam logic [3:0] SYSBUS_WRITE = 4'h2;
    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = BUS_DATA_WIDTH - 6;
    localparam int LW = $clog2(READ_LATENCY + 2);

    typedef enum logic [2:0] {IDLE, LAT, RDATA, WDATA, WDONE} state_t;

    state_t                    state, state_n;
    logic [2:0]                beat, beat_n;
    logic [LW-1:0]             lat_cnt, lat_n;
    logic [BW-1:0]             base, base_n;
    logic [BUS_TAG_WIDTH-1:0]  tag, tag_n;
    logic                      reqack_n, respcyc_n;
    logic [BUS_DATA_WIDTH-1:0] resp_n;
    logic                      mem_we;
    logic [AW-1:0]             wr_idx;

    // Backing store; deliberately not reset so contents survive reset.
    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Word index is the line base concatenated with the beat, truncated so high addresses alias.
    function automatic logic [AW-1:0] word_idx(input logic [BW-1:0] b, input logic [2:0] bt);
        return AW'({b, bt});
    endfunction

    assign wr_idx      = word_idx(base, beat);
    assign bus_resptag = tag;

    // State and registered outputs; everything here clears asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            beat        <= '0;
            lat_cnt     <= '0;
            base        <= '0;
            tag         <= '0;
            bus_reqack  <= 1'b0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
        end else begin
            state       <= state_n;
            beat        <= beat_n;
            lat_cnt     <= lat_n;
            base        <= base_n;
            tag         <= tag_n;
            bus_reqack  <= reqack_n;
            bus_respcyc <= respcyc_n;
            bus_resp    <= resp_n;
        end
    end

    // Next-state and next-output decode; read data is fetched one cycle ahead into the output register.
    always_comb begin
        state_n   = state;
        beat_n    = beat;
        lat_n     = lat_cnt;
        base_n    = base;
        tag_n     = tag;
        reqack_n  = bus_reqack;
        respcyc_n = bus_respcyc;
        resp_n    = bus_resp;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                reqack_n = 1'b0;
                if (bus_reqcyc && bus_reqtag[12]) begin
                    base_n   = bus_req[BUS_DATA_WIDTH-1:6];
                    tag_n    = bus_reqtag;
                    reqack_n = 1'b1;
                    beat_n   = '0;
                    lat_n    = '0;
                    case (bus_reqtag[11:8])
                        SYSBUS_READ:  state_n = LAT;
                        SYSBUS_WRITE: state_n = WDATA;
                        default: begin
                            // Unknown commands complete immediately with a single zero beat.
                            state_n   = WDONE;
                            respcyc_n = 1'b1;
                            resp_n    = '0;
                        end
                    endcase
                end
            end
            LAT: begin
                reqack_n = 1'b0;
                if (lat_cnt == LW'(READ_LATENCY)) begin
                    state_n   = RDATA;
                    respcyc_n = 1'b1;
                    beat_n    = '0;
                    resp_n    = mem[word_idx(base, 3'd0)];
                end else begin
                    lat_n = lat_cnt + 1'b1;
                end
            end
            RDATA: begin
                if (bus_respack) begin
                    if (beat == 3'd7) begin
                        state_n   = IDLE;
                        respcyc_n = 1'b0;
                        resp_n    = '0;
                        beat_n    = '0;
                    end else begin
                        beat_n = beat + 3'd1;
                        resp_n = mem[word_idx(base, beat + 3'd1)];
                    end
                end
            end
            WDATA: begin
                if (bus_reqcyc) begin
                    mem_we = 1'b1;
                    if (beat == 3'd7) begin
                        state_n   = WDONE;
                        reqack_n  = 1'b0;
                        respcyc_n = 1'b1;
                        resp_n    = '0;
                        beat_n    = '0;
                    end else begin
                        beat_n = beat + 3'd1;
                    end
                end
            end
            WDONE: begin
                reqack_n = 1'b0;
                if (bus_respack) begin
                    state_n   = IDLE;
                    respcyc_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Write port of the backing store.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= bus_req;
        end
    end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
module tb_sysbus_mem_responder;

    localparam int MW = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;

    int checks = 0;
    int errors = 0;

    logic [63:0] rd_dat [8];
    logic [12:0] rd_tag [8];
    int lat, burst, ack_cnt, stall_bad, timeout;

    sysbus_mem_responder #(
        .BUS_TAG_WIDTH (13),
        .BUS_DATA_WIDTH(64),
        .MEM_WORDS     (MW),
        .READ_LATENCY  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_reqcyc (bus_reqcyc),
        .bus_req    (bus_req),
        .bus_reqtag (bus_reqtag),
        .bus_reqack (bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_resp   (bus_resp),
        .bus_resptag(bus_resptag),
        .bus_respack(bus_respack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full-line write with data d0+i, completion accepted at once.
    task automatic bus_write(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] d0);
        bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag; bus_respack = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            bus_req = d0 + 64'(i);
            tick();
        end
        bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
        checks++;
        if (bus_respcyc !== 1'b1) begin
            errors++;
            $display("FAIL preload_wdone respcyc got %b want 1", bus_respcyc);
        end
        bus_respack = 1'b1;
        tick();
        bus_respack = 1'b0;
    endtask

    // Read one line; beats sa_beat and sb_beat are stalled 3 cycles each (-1 = no stall).
    task automatic bus_read(input logic [63:0] addr, input logic [12:0] tag, input int sa_beat, input int sb_beat);
        int n, beat, stall;
        logic [63:0] hold;
        lat = 0; burst = 0; ack_cnt = 0; stall_bad = 0; timeout = 0; hold = '0;
        for (int i = 0; i < 8; i++) begin
            rd_dat[i] = '0;
            rd_tag[i] = '0;
        end
        bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag; bus_respack = 1'b0;
        tick();
        bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
        n = 0;
        while (bus_respcyc !== 1'b1 && n < 40) begin
            if (bus_reqack === 1'b1) ack_cnt++;
            tick();
            n++;
        end
        lat = n;
        if (n == 40) begin
            timeout = 1;
            return;
        end
        beat = 0; stall = 0;
        while (beat < 8 && burst < 64) begin
            if (bus_respcyc !== 1'b1) begin
                timeout = 1;
                break;
            end
            if ((beat == sa_beat || beat == sb_beat) && stall < 3) begin
                if (stall == 0) hold = bus_resp;
                else if (bus_resp !== hold) stall_bad++;
                stall++;
                bus_respack = 1'b0;
            end else begin
                if (stall > 0 && bus_resp !== hold) stall_bad++;
                rd_dat[beat] = bus_resp;
                rd_tag[beat] = bus_resptag;
                beat++;
                stall = 0;
                bus_respack = 1'b1;
            end
            tick();
            burst++;
        end
        bus_respack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b0;
        tick(); tick();
        checks++; if (bus_reqack !== 1'b0) begin errors++; $display("FAIL reset_reqack got %b want 0", bus_reqack); end
        checks++; if (bus_respcyc !== 1'b0) begin errors++; $display("FAIL reset_respcyc got %b want 0", bus_respcyc); end
        checks++; if (bus_resp !== 64'h0) begin errors++; $display("FAIL reset_resp got %h want 0", bus_resp); end
        checks++; if (bus_resptag !== 13'h0) begin errors++; $display("FAIL reset_resptag got %h want 0", bus_resptag); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_read_basic();
        logic [63:0] exp;
        bus_write(64'h200, 13'h1201, 64'h1000);
        bus_read(64'h208, 13'h1105, -1, -1);
        checks++; if (timeout !== 0) begin errors++; $display("FAIL rd_timeout got %0d want 0", timeout); end
        checks++; if (ack_cnt !== 1) begin errors++; $display("FAIL rd_ack_cycles got %0d want 1", ack_cnt); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL rd_latency got %0d want 5", lat); end
        checks++; if (burst !== 8) begin errors++; $display("FAIL rd_burst got %0d want 8", burst); end
        for (int i = 0; i < 8; i++) begin
            exp = 64'h1000 + 64'(i);
            checks++;
            if (rd_dat[i] !== exp || rd_tag[i] !== 13'h1105) begin
                errors++;
                $display("FAIL rd_beat%0d got %h/%h want %h/1105", i, rd_dat[i], rd_tag[i], exp);
            end
        end
        checks++; if (bus_respcyc !== 1'b0) begin errors++; $display("FAIL rd_end_respcyc got %b want 0", bus_respcyc); end
    endtask

    task automatic test_read_stall();
        logic [63:0] exp;
        bus_read(64'h208, 13'h1105, 2, 5);
        checks++; if (burst !== 14) begin errors++; $display("FAIL stall_burst got %0d want 14", burst); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold got %0d changes want 0", stall_bad); end
        for (int i = 0; i < 8; i++) begin
            exp = 64'h1000 + 64'(i);
            checks++;
            if (rd_dat[i] !== exp) begin errors++; $display("FAIL stall_beat%0d got %h want %h", i, rd_dat[i], exp); end
        end
    endtask

    task automatic test_write();
        int bad_ack;
        logic [63:0] exp;
        bad_ack = 0;
        bus_reqcyc = 1'b1; bus_req = 64'h1C0; bus_reqtag = 13'h1207; bus_respack = 1'b0;
        tick();
        checks++; if (bus_reqack !== 1'b1) begin errors++; $display("FAIL wr_ack_rise got %b want 1", bus_reqack); end
        for (int i = 0; i < 8; i++) begin
            if (i == 3 || i == 6) begin
                bus_reqcyc = 1'b0; bus_req = 64'hDEAD;
                tick();
                if (bus_reqack !== 1'b1) bad_ack++;
            end
            bus_reqcyc = 1'b1; bus_req = 64'hA0 + 64'(i);
            tick();
            if (i < 7 && bus_reqack !== 1'b1) bad_ack++;
        end
        bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
        checks++; if (bad_ack !== 0) begin errors++; $display("FAIL wr_ack_held got %0d drops want 0", bad_ack); end
        checks++; if (bus_reqack !== 1'b0) begin errors++; $display("FAIL wr_ack_fall got %b want 0", bus_reqack); end
        checks++;
        if (bus_respcyc !== 1'b1 || bus_resp !== 64'h0 || bus_resptag !== 13'h1207) begin
            errors++;
            $display("FAIL wr_done got %b/%h/%h want 1/0/1207", bus_respcyc, bus_resp, bus_resptag);
        end
        tick();
        checks++; if (bus_respcyc !== 1'b1) begin errors++; $display("FAIL wr_done_hold got %b want 1", bus_respcyc); end
        bus_respack = 1'b1;
        tick();
        bus_respack = 1'b0;
        checks++; if (bus_respcyc !== 1'b0) begin errors++; $display("FAIL wr_done_end got %b want 0", bus_respcyc); end
        bus_read(64'h1C0, 13'h1106, -1, -1);
        for (int i = 0; i < 8; i++) begin
            exp = 64'hA0 + 64'(i);
            checks++;
            if (rd_dat[i] !== exp) begin errors++; $display("FAIL wr_readback%0d got %h want %h", i, rd_dat[i], exp); end
        end
    endtask

    task automatic test_non_memory();
        int acks, resps;
        acks = 0; resps = 0;
        bus_reqcyc = 1'b1; bus_req = 64'h200; bus_reqtag = 13'h0105; bus_respack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_reqack !== 1'b0) acks++;
            if (bus_respcyc !== 1'b0) resps++;
        end
        bus_reqcyc = 1'b0; bus_respack = 1'b0;
        checks++; if (acks !== 0) begin errors++; $display("FAIL nonmem_ack got %0d want 0", acks); end
        checks++; if (resps !== 0) begin errors++; $display("FAIL nonmem_resp got %0d want 0", resps); end
        bus_read(64'h208, 13'h1105, -1, -1);
        checks++;
        if (lat !== 5 || rd_dat[0] !== 64'h1000 || rd_dat[7] !== 64'h1007) begin
            errors++;
            $display("FAIL nonmem_follow got lat %0d %h..%h want 5 1000..1007", lat, rd_dat[0], rd_dat[7]);
        end
    endtask

    task automatic test_back_to_back();
        bus_read(64'h1C0, 13'h1101, -1, -1);
        bus_read(64'h200, 13'h1102, -1, -1);
        checks++;
        if (lat !== 5 || burst !== 8 || rd_dat[3] !== 64'h1003 || rd_tag[3] !== 13'h1102) begin
            errors++;
            $display("FAIL b2b got lat %0d burst %0d %h/%h want 5 8 1003/1102", lat, burst, rd_dat[3], rd_tag[3]);
        end
    endtask

    task automatic test_reset_mid_read();
        int n;
        logic [63:0] exp;
        bus_reqcyc = 1'b1; bus_req = 64'h208; bus_reqtag = 13'h1105; bus_respack = 1'b0;
        tick();
        bus_reqcyc = 1'b0;
        n = 0;
        while (bus_respcyc !== 1'b1 && n < 40) begin tick(); n++; end
        bus_respack = 1'b1;
        tick(); tick(); tick();
        checks++; if (bus_resp !== 64'h1003) begin errors++; $display("FAIL rst_mid_beat3 got %h want 1003", bus_resp); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus_reqack !== 1'b0 || bus_respcyc !== 1'b0 || bus_resp !== 64'h0 || bus_resptag !== 13'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs got %b/%b/%h/%h want 0/0/0/0", bus_reqack, bus_respcyc, bus_resp, bus_resptag);
        end
        bus_respack = 1'b0;
        tick();
        @(negedge clk);
        reset = 1'b1;
        bus_read(64'h208, 13'h1105, -1, -1);
        for (int i = 0; i < 8; i++) begin
            exp = 64'h1000 + 64'(i);
            checks++;
            if (rd_dat[i] !== exp) begin errors++; $display("FAIL rst_after%0d got %h want %h", i, rd_dat[i], exp); end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] exp;
        bus_write(64'h40, 13'h1203, 64'hB0);
        bus_read(64'(MW * 8 + 'h40), 13'h1107, -1, -1);
        for (int i = 0; i < 8; i++) begin
            exp = 64'hB0 + 64'(i);
            checks++;
            if (rd_dat[i] !== exp) begin errors++; $display("FAIL wrap%0d got %h want %h", i, rd_dat[i], exp); end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_read_stall();
        test_write();
        test_non_memory();
        test_back_to_back();
        test_reset_mid_read();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysbus_mem_responder.md
# sysbus_mem_responder

Memory-side responder for the system bus used by the instruction cache. It accepts line-fill read requests and line write-backs from a single bus initiator. It serves them from an internal backing store of 64-bit words, returning each read as an 8-beat burst of one 64-byte line. It sits at the far end of the bus from the cache and is the default memory model for simulation and bring-up.

## Interface
Parameters:
- BUS_TAG_WIDTH, 13, request/response tag width
- BUS_DATA_WIDTH, 64, data/address bus width
- MEM_WORDS, 4096, backing-store depth in 64-bit words; power of two, at least 8
- READ_LATENCY, 4, idle cycles between request acceptance and the first read beat; 0 or more

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state and outputs
- bus_reqcyc  in  1  initiator presents a request or write-data beat
- bus_req  in  64  address beat (byte address), then write-data beats
- bus_reqtag  in  13  [12] target (1 = memory), [11:8] command, [7:0] transaction id
- bus_reqack  out  1  responder accepted the address beat / ready for write data
- bus_respcyc  out  1  response beat valid
- bus_resp  out  64  response data
- bus_resptag  out  13  tag of the transaction being answered, unchanged
- bus_respack  in  1  initiator accepts the current response beat

## Operation
- States: IDLE, LAT, RDATA, WDATA, WDONE.
- IDLE: on an edge with bus_reqcyc=1 and bus_reqtag[12]=1, latch the line base (bus_req[63:6]) and the full tag, and set bus_reqack=1 for the next cycle. bus_reqtag[12]=0 is ignored: no ack, stay in IDLE.
- Command decode uses bus_reqtag[11:8]:
  - `SYSBUS_READ` goes to LAT.
  - `SYSBUS_WRITE` goes to WDATA.
  - Any other value goes to WDONE and returns a single completion beat.
- LAT: count down READ_LATENCY cycles, then go to RDATA. When READ_LATENCY=0, go directly to RDATA.
- RDATA: bus_respcyc=1, bus_resptag=latched tag, bus_resp=mem[{base,beat} mod MEM_WORDS], beat 0..7 ascending.
  - A beat is transferred on an edge where bus_respcyc=1 and bus_respack=1; the beat counter advances on that edge.
  - Without bus_respack, the current beat and data are held.
  - After beat 7 transfers: bus_respcyc=0, return to IDLE.
- WDATA: bus_reqack held 1.
  - Each edge with bus_reqcyc=1 writes bus_req to mem[{base,beat}] and advances the beat counter.
  - Cycles with bus_reqcyc=0 are bubbles and write nothing.
  - After beat 7: bus_reqack=0, go to WDONE.
- WDONE: one beat with bus_respcyc=1, bus_resp=0, bus_resptag=latched tag, held until bus_respack. Then return to IDLE.
- Address arithmetic: the word index is the low log2(MEM_WORDS) bits of {bus_req[63:6], beat[2:0]}, so higher addresses alias (wrap). bus_req[5:0] is ignored; bursts always start at offset 0 of the line.
- Only one transaction is outstanding at a time. bus_reqcyc outside IDLE/WDATA is not acknowledged and stays pending until IDLE.

## Timing
- Reset values: bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0; state IDLE, counters 0.
- Backing-store contents are not reset; they survive reset.
- Reset asserted mid-burst aborts the transaction immediately. Outputs go to 0 asynchronously. Partially written lines keep the beats already written.
- All outputs are registered; no combinational path from inputs to outputs.
- Read latency, with the request sampled at edge E0:
  - bus_reqack is high for exactly the cycle E0..E1.
  - Beat 0 is valid from edge E1+READ_LATENCY.
  - Minimum burst is 8 cycles when bus_respack is held 1.
- Write: bus_reqack rises after E0, stays high until the edge accepting beat 7, then falls. The completion beat is valid the cycle after beat 7.
- Back-to-back: after the final response beat is accepted, state is IDLE on that same edge. The next request can be sampled on the following edge.
- Simultaneous events: bus_reqcyc arriving while bus_respcyc is high is not acknowledged until the burst ends.

## Test plan
- Preload mem[0x40..0x47]=0x1000+i. Send a read of address 0x208, tag `SYSBUS_READ`<<8|1<<12|0x05, READ_LATENCY=4, bus_respack tied 1. Expect:
  - bus_reqack for 1 cycle.
  - respcyc rises 5 cycles after the acceptance edge.
  - 8 beats 0x1000..0x1007, all with tag 0x05 fields.
- Same read with bus_respack low on beats 2 and 5 for 3 cycles each -> data held during stalls, no skipped or duplicated beats, burst takes 14 cycles.
- Write to 0x1C0 with data 0xA0..0xA7 and two reqcyc bubbles, then read 0x1C0 -> completion beat with data 0 and the write tag; read returns 0xA0..0xA7.
- Request with bus_reqtag[12]=0 -> no bus_reqack and no response for 20 cycles; a following memory request is served normally.
- Assert reset mid-read at beat 3 -> all outputs 0 within the cycle. After release, a new read is served with correct data, and the backing store is unchanged.
- Read at address MEM_WORDS*8 + 0x40 -> returns the same data as a read at 0x40 (wrap-around).
